// File: rtl/app_scheduler.sv
// Menu/launcher for eight applications driven by nine debounced keys.
// Define ESCAPE_KEY_EN to make key 7 an exit request while an application runs.
module app_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] keys,
  input  logic [7:0] en_back,
  output logic [7:0] en_sub,
  output logic [8:0] key_evt,
  output logic [2:0] sel,
  output logic       in_menu
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {MENU, LAUNCH, RUN, EXIT} state_e;

  logic [8:0]    s1_q, s2_q;
  logic [1:0]    vld_q;
  logic [8:0]    lvl_q, prev_q, armed_q;
  logic [CW-1:0] cnt_q [9];
  logic [8:0]    press;
  logic [8:0]    fwd_mask;
  logic          exit_req;

  state_e        state_q;
  logic [2:0]    sel_q;
  logic [7:0]    en_sub_q;

  // A key is armed only after it has been seen released once the synchronizer
  // holds real samples, so a key held through reset cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      vld_q   <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      armed_q <= '0;
      for (int unsigned k = 0; k < 9; k++) cnt_q[k] <= '0;
    end else begin
      s1_q   <= keys;
      s2_q   <= s1_q;
      vld_q  <= {vld_q[0], 1'b1};
      prev_q <= lvl_q;
      if (vld_q[1]) armed_q <= armed_q | ~s2_q;
      for (int unsigned k = 0; k < 9; k++) begin
        if (s2_q[k] == lvl_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[k] <= '0;
          lvl_q[k] <= ~lvl_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign press = lvl_q & ~prev_q & armed_q;

  always_comb begin
    fwd_mask = '1;
    exit_req = en_back[sel_q];
`ifdef ESCAPE_KEY_EN
    fwd_mask[7] = 1'b0;
    exit_req    = en_back[sel_q] | press[7];
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MENU;
      sel_q    <= '0;
      en_sub_q <= '0;
    end else begin
      case (state_q)
        MENU: begin
          if (press[8]) begin
            state_q  <= LAUNCH;
            en_sub_q <= 8'd1 << sel_q;
          end else if (press[0] && !press[1]) begin
            sel_q <= sel_q - 3'd1;
          end else if (press[1] && !press[0]) begin
            sel_q <= sel_q + 3'd1;
          end
        end
        LAUNCH: state_q <= RUN;
        RUN: begin
          if (exit_req) begin
            state_q  <= EXIT;
            en_sub_q <= '0;
          end
        end
        EXIT: if (lvl_q == '0) state_q <= MENU;
        default: state_q <= MENU;
      endcase
    end
  end

  assign en_sub  = en_sub_q;
  assign sel     = sel_q;
  assign in_menu = (state_q == MENU);
  assign key_evt = (state_q == RUN) ? (press & fwd_mask) : '0;

endmodule

// File: tb/tb_app_scheduler.sv
// Randomized and directed bench for app_scheduler (DEBOUNCE_CYCLES = 4) with an
// edge-indexed history model of the key path and a plain menu/run state model.
module tb_app_scheduler;

  localparam int D = 4;
`ifdef ESCAPE_KEY_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [8:0] keys;
  logic [7:0] en_back;
  logic [7:0] en_sub;
  logic [8:0] key_evt;
  logic [2:0] sel;
  logic       in_menu;

  int n_checks;
  int n_errors;

  app_scheduler #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .keys    (keys),
    .en_back (en_back),
    .en_sub  (en_sub),
    .key_evt (key_evt),
    .sel     (sel),
    .in_menu (in_menu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: edges counted from reset release, raw samples per edge.
  int         n_edge;
  logic [8:0] raw [$];
  logic [8:0] dbh [$];
  logic [8:0] m_lvl, m_armed, m_press;
  int         m_state;  // 0 menu, 1 launch, 2 run, 3 exit
  logic [2:0] m_sel;
  logic [7:0] m_en;
  logic [8:0] evt_acc;
  int         evt_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    raw.delete();
    dbh.delete();
    m_lvl   = '0;
    m_armed = '0;
    m_press = '0;
    m_state = 0;
    m_sel   = '0;
    m_en    = '0;
  endtask

  function automatic logic [8:0] m_evt();
    if (m_state != 2) return '0;
    return ESC ? (m_press & 9'h17F) : m_press;
  endfunction

  task automatic model_edge();
    logic [8:0] sv, nl, na;
    bit         flip;
    n_edge++;
    raw.push_back(keys);
    sv = (n_edge >= 3) ? raw[n_edge - 3] : 9'h000;
    dbh.push_back(sv);
    case (m_state)
      0: begin
        if (m_press[8]) begin
          m_state = 1;
          m_en    = 8'd1 << m_sel;
        end else if (m_press[0] && !m_press[1]) begin
          m_sel = 3'((int'(m_sel) + 7) % 8);
        end else if (m_press[1] && !m_press[0]) begin
          m_sel = 3'((int'(m_sel) + 1) % 8);
        end
      end
      1: m_state = 2;
      2: if (en_back[m_sel] || (ESC && m_press[7])) begin
        m_state = 3;
        m_en    = '0;
      end
      default: if (m_lvl == '0) m_state = 0;
    endcase
    // A level flips once the last D synchronized samples all disagree with it.
    nl = m_lvl;
    if (dbh.size() >= D) begin
      for (int k = 0; k < 9; k++) begin
        flip = 1'b1;
        for (int j = 1; j <= D; j++)
          if (dbh[dbh.size() - j][k] == m_lvl[k]) flip = 1'b0;
        if (flip) nl[k] = ~m_lvl[k];
      end
    end
    na      = m_armed | ((n_edge >= 3) ? ~sv : 9'h000);
    m_press = nl & ~m_lvl & na;
    m_lvl   = nl;
    m_armed = na;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("en_sub", 32'(en_sub), 32'(m_en));
    check("sel", 32'(sel), 32'(m_sel));
    check("in_menu", 32'(in_menu), 32'(m_state == 0));
    check("key_evt", 32'(key_evt), 32'(m_evt()));
    if (key_evt != '0) begin
      evt_acc |= key_evt;
      evt_cnt++;
    end
  endtask

  task automatic press_key(input int k, input int hold);
    keys = keys | (9'd1 << k);
    repeat (hold) step();
    keys = keys & ~(9'd1 << k);
    repeat (D + 8) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    evt_acc  = '0;
    evt_cnt  = 0;
    rst_n    = 1'b0;
    keys     = '0;
    en_back  = '0;
    model_reset();
    #12;
    check("rst_en_sub", 32'(en_sub), 32'h00);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_in_menu", 32'(in_menu), 32'h1);
    check("rst_key_evt", 32'(key_evt), 32'h000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();

    // Short glitch rejected, held key accepted after 2 + D + 1 edges.
    keys[1] = 1'b1;
    repeat (3) step();
    keys[1] = 1'b0;
    repeat (10) step();
    check("glitch_sel", 32'(sel), 32'h0);
    keys[1] = 1'b1;
    repeat (6) step();
    check("deb_sel_6", 32'(sel), 32'h0);
    step();
    check("deb_sel_7", 32'(sel), 32'h1);
    keys[1] = 1'b0;
    repeat (10) step();
    press_key(0, 8);
    press_key(0, 8);
    check("wrap_down", 32'(sel), 32'h7);
    press_key(1, 8);
    check("wrap_up", 32'(sel), 32'h0);

    // Launch entry 2 and forward a press.
    press_key(1, 8);
    press_key(1, 8);
    check("sel_two", 32'(sel), 32'h2);
    keys[8] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!in_menu) break;
    end
    check("launch_en", 32'(en_sub), 32'h04);
    check("launch_menu", 32'(in_menu), 32'h0);
    keys[8] = 1'b0;
    repeat (10) step();
    evt_acc = '0;
    evt_cnt = 0;
    press_key(3, 8);
    check("fwd_evt", 32'(evt_acc), 32'h008);
    check("fwd_cnt", 32'(evt_cnt), 32'd1);

    // Exit only on en_back[sel]; menu only after every key is released.
    en_back = 8'h01;
    repeat (5) step();
    check("foreign_back", 32'(en_sub), 32'h04);
    en_back = 8'h00;
    keys[5] = 1'b1;
    repeat (10) step();
    en_back = 8'h04;
    step();
    check("exit_en", 32'(en_sub), 32'h00);
    en_back = 8'h00;
    repeat (10) step();
    check("exit_hold", 32'(in_menu), 32'h0);
    keys[5] = 1'b0;
    repeat (10) step();
    check("exit_menu", 32'(in_menu), 32'h1);

    // Key 7 in RUN.
    press_key(8, 8);
    evt_acc = '0;
    press_key(7, 8);
`ifdef ESCAPE_KEY_EN
    check("esc_evt", 32'(evt_acc), 32'h000);
    check("esc_en", 32'(en_sub), 32'h00);
    check("esc_menu", 32'(in_menu), 32'h1);
`else
    check("k7_evt", 32'(evt_acc), 32'h080);
    check("k7_en", 32'(en_sub), 32'h04);
    en_back = 8'h04;
    step();
    en_back = 8'h00;
    repeat (6) step();
    check("k7_menu", 32'(in_menu), 32'h1);
`endif

    // Asynchronous reset mid-RUN with key 8 held.
    press_key(8, 8);
    check("run_again", 32'(en_sub), 32'h04);
    keys[8] = 1'b1;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en_sub", 32'(en_sub), 32'h00);
    check("arst_sel", 32'(sel), 32'h0);
    check("arst_in_menu", 32'(in_menu), 32'h1);
    check("arst_key_evt", 32'(key_evt), 32'h000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step();
    check("no_relaunch", 32'(in_menu), 32'h1);
    keys[8] = 1'b0;
    repeat (10) step();
    press_key(8, 8);
    check("relaunch_en", 32'(en_sub), 32'h01);

    // Random key activity and exit requests against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) keys[$urandom_range(0, 8)] ^= 1'b1;
      en_back = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
